// File: rtl/reg_desc_issuer_pkg.sv
// Shared types and register map for the descriptor issuer that programs the DMA frontend.
package reg_desc_issuer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SRC,
    ST_WR_DST,
    ST_WR_LEN,
    ST_RD_ID,
    ST_POLL,
    ST_REPORT
  } state_e;

  // Byte offsets from the frontend register base.
  localparam logic [7:0] OFF_SRC     = 8'h00;
  localparam logic [7:0] OFF_DST     = 8'h08;
  localparam logic [7:0] OFF_LEN     = 8'h10;
  localparam logic [7:0] OFF_NEXT_ID = 8'h28;
  localparam logic [7:0] OFF_DONE    = 8'h30;

endpackage

// File: rtl/reg_desc_issuer.sv
// Issues one DMA descriptor as SRC/DST/LEN register writes, reads the launch ID, polls DONE and reports.
// Optional build macro REG_DESC_ISSUER_TIMEOUT_EN bounds the DONE poll to PollLimit reads.
module reg_desc_issuer
  import reg_desc_issuer_pkg::*;
#(
  parameter int unsigned              AxiDataWidth = 64,
  parameter int unsigned              AxiAddrWidth = 64,
  parameter logic [AxiAddrWidth-1:0]  RegBase      = '0,
  parameter int unsigned              PollLimit    = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AxiAddrWidth-1:0]     desc_src_i,
  input  logic [AxiAddrWidth-1:0]     desc_dst_i,
  input  logic [AxiAddrWidth-1:0]     desc_len_i,
  input  logic                        desc_valid_i,
  output logic                        desc_ready_o,
  output logic [AxiAddrWidth-1:0]     reg_req_addr,
  output logic                        reg_req_write,
  output logic [AxiDataWidth-1:0]     reg_req_wdata,
  output logic [AxiDataWidth/8-1:0]   reg_req_wstrb,
  output logic                        reg_req_valid,
  input  logic [AxiDataWidth-1:0]     reg_rsp_rdata,
  input  logic                        reg_rsp_error,
  input  logic                        reg_rsp_ready,
  output logic                        done_valid_o,
  input  logic                        done_ready_i,
  output logic                        done_error_o,
  output logic [AxiDataWidth-1:0]     done_id_o
);

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] src_q, src_d;
  logic [AxiAddrWidth-1:0] dst_q, dst_d;
  logic [AxiAddrWidth-1:0] len_q, len_d;
  logic [AxiDataWidth-1:0] id_q, id_d;
  logic                    err_q, err_d;
  logic                    req_hs;
  logic                    desc_accept;

`ifdef REG_DESC_ISSUER_TIMEOUT_EN
  localparam int unsigned PollCntW = $clog2(PollLimit + 1);
  logic [PollCntW-1:0] poll_cnt_q, poll_cnt_d;
`endif

  assign req_hs      = reg_req_valid && reg_rsp_ready;
  assign desc_accept = desc_valid_i && desc_ready_o;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
`ifdef REG_DESC_ISSUER_TIMEOUT_EN
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      id_q    <= id_d;
      err_q   <= err_d;
`ifdef REG_DESC_ISSUER_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  // NOTE: every variable gets a default first so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    id_d    = id_q;
    err_d   = err_q;
`ifdef REG_DESC_ISSUER_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (desc_accept) begin
          src_d   = desc_src_i;
          dst_d   = desc_dst_i;
          len_d   = desc_len_i;
          id_d    = '0;
          err_d   = 1'b0;
          state_d = (desc_len_i == '0) ? ST_REPORT : ST_WR_SRC;
        end
      end
      ST_WR_SRC: if (req_hs) state_d = ST_WR_DST;
      ST_WR_DST: if (req_hs) state_d = ST_WR_LEN;
      ST_WR_LEN: if (req_hs) state_d = ST_RD_ID;
      ST_RD_ID: begin
        if (req_hs) begin
          id_d    = reg_rsp_rdata;
          state_d = ST_POLL;
`ifdef REG_DESC_ISSUER_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      ST_POLL: begin
        if (req_hs) begin
          if (reg_rsp_rdata == id_q) begin
            state_d = ST_REPORT;
          end
`ifdef REG_DESC_ISSUER_TIMEOUT_EN
          else if (poll_cnt_q == PollCntW'(PollLimit - 1)) begin
            state_d = ST_REPORT;
            err_d   = 1'b1;
          end
          poll_cnt_d = poll_cnt_q + 1'b1;
`endif
        end
      end
      ST_REPORT: if (done_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A slave error ends the descriptor regardless of which transaction it hit.
    if (req_hs && reg_rsp_error) begin
      state_d = ST_REPORT;
      err_d   = 1'b1;
      id_d    = id_q;
    end
  end

  always_comb begin
    reg_req_valid = 1'b0;
    reg_req_write = 1'b0;
    reg_req_addr  = '0;
    reg_req_wdata = '0;
    reg_req_wstrb = '0;
    case (state_q)
      ST_WR_SRC: begin
        reg_req_valid = 1'b1;
        reg_req_write = 1'b1;
        reg_req_addr  = RegBase + AxiAddrWidth'(OFF_SRC);
        reg_req_wdata = AxiDataWidth'(src_q);
        reg_req_wstrb = '1;
      end
      ST_WR_DST: begin
        reg_req_valid = 1'b1;
        reg_req_write = 1'b1;
        reg_req_addr  = RegBase + AxiAddrWidth'(OFF_DST);
        reg_req_wdata = AxiDataWidth'(dst_q);
        reg_req_wstrb = '1;
      end
      ST_WR_LEN: begin
        reg_req_valid = 1'b1;
        reg_req_write = 1'b1;
        reg_req_addr  = RegBase + AxiAddrWidth'(OFF_LEN);
        reg_req_wdata = AxiDataWidth'(len_q);
        reg_req_wstrb = '1;
      end
      ST_RD_ID: begin
        reg_req_valid = 1'b1;
        reg_req_addr  = RegBase + AxiAddrWidth'(OFF_NEXT_ID);
      end
      ST_POLL: begin
        reg_req_valid = 1'b1;
        reg_req_addr  = RegBase + AxiAddrWidth'(OFF_DONE);
      end
      default: ;
    endcase
  end

  assign desc_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign done_valid_o = (state_q == ST_REPORT);
  assign done_error_o = (state_q == ST_REPORT) && err_q;
  assign done_id_o    = (state_q == ST_REPORT) ? id_q : '0;

endmodule

// File: tb/tb_reg_desc_issuer.sv
// Self-checking bench for reg_desc_issuer: a queue-based model lists the register transactions
// and final report each descriptor must produce, and a bench slave answers the requests.
module tb_reg_desc_issuer;

  localparam int          PL   = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] desc_src_i, desc_dst_i, desc_len_i;
  logic        desc_valid_i, desc_ready_o;
  logic [63:0] reg_req_addr, reg_req_wdata;
  logic        reg_req_write, reg_req_valid;
  logic [7:0]  reg_req_wstrb;
  logic [63:0] reg_rsp_rdata;
  logic        reg_rsp_error, reg_rsp_ready;
  logic        done_valid_o, done_ready_i, done_error_o;
  logic [63:0] done_id_o;

  always #5 clk_i = ~clk_i;

  reg_desc_issuer #(.AxiDataWidth(64), .AxiAddrWidth(64), .RegBase(BASE), .PollLimit(PL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i), .desc_len_i(desc_len_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .reg_req_addr(reg_req_addr), .reg_req_write(reg_req_write), .reg_req_wdata(reg_req_wdata),
    .reg_req_wstrb(reg_req_wstrb), .reg_req_valid(reg_req_valid),
    .reg_rsp_rdata(reg_rsp_rdata), .reg_rsp_error(reg_rsp_error), .reg_rsp_ready(reg_rsp_ready),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_error_o(done_error_o), .done_id_o(done_id_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [63:0] exp_id;
  logic        exp_err;

  // Scenario knobs: launch ID, 1-based poll read that matches, transaction index to error, forced stall.
  logic [63:0] sc_next_id;
  int          sc_match;
  int          sc_err_idx;
  int          sc_stall_idx;
  int          sc_stall_cycles;

  // Observations of the last descriptor, used by the literal expectations.
  int          n_wr, n_rd, n_valid_cycles, stall_obs;
  logic [63:0] got_id;
  logic        got_err;

  function automatic txn_t mk(input bit wr, input logic [7:0] off, input logic [63:0] data);
    txn_t t;
    t.wr   = wr;
    t.addr = BASE + {56'd0, off};
    t.data = wr ? data : 64'd0;
    return t;
  endfunction

  task automatic build_model(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] len);
    int polls;
    bit timed_out;
    exp_q.delete();
    polls     = sc_match;
    timed_out = 1'b0;
`ifdef REG_DESC_ISSUER_TIMEOUT_EN
    if (polls > PL) begin
      polls     = PL;
      timed_out = 1'b1;
    end
`endif
    if (len != 0) begin
      exp_q.push_back(mk(1'b1, 8'h00, src));
      exp_q.push_back(mk(1'b1, 8'h08, dst));
      exp_q.push_back(mk(1'b1, 8'h10, len));
      exp_q.push_back(mk(1'b0, 8'h28, 64'd0));
      for (int p = 0; p < polls; p++) exp_q.push_back(mk(1'b0, 8'h30, 64'd0));
      exp_err = timed_out;
      exp_id  = sc_next_id;
    end else begin
      exp_err = 1'b0;
      exp_id  = 64'd0;
    end
    if (sc_err_idx >= 0 && sc_err_idx < exp_q.size()) begin
      while (exp_q.size() > sc_err_idx + 1) void'(exp_q.pop_back());
      exp_err = 1'b1;
      exp_id  = (sc_err_idx >= 4) ? sc_next_id : 64'd0;
    end
  endtask

  function automatic logic [63:0] slave_rdata(input int idx);
    if (idx == 3) return sc_next_id;
    if (idx >= 4) return ((idx - 3) == sc_match) ? sc_next_id : ~sc_next_id;
    return {$urandom, $urandom};
  endfunction

  // Drives one descriptor and checks every cycle until it is reported and released.
  // abort_idx >= 0 asserts reset while that transaction is pending instead of completing.
  task automatic run_desc(input string tag, input logic [63:0] src, input logic [63:0] dst,
                          input logic [63:0] len, input int abort_idx);
    int  idx;
    int  stall_left;
    bit  fin;
    bit  go;
    txn_t t;
    idx = 0;
    fin = 1'b0;
    stall_left = sc_stall_cycles;
    n_wr = 0; n_rd = 0; n_valid_cycles = 0; stall_obs = 0;
    got_id = 'x; got_err = 1'bx;
    build_model(src, dst, len);

    @(negedge clk_i);
    check({tag, " idle desc_ready"}, {63'd0, desc_ready_o}, 64'd1);
    check({tag, " idle req_valid"}, {63'd0, reg_req_valid}, 64'd0);
    desc_src_i = src; desc_dst_i = dst; desc_len_i = len; desc_valid_i = 1'b1;
    @(negedge clk_i);
    desc_valid_i = 1'b0;
    desc_src_i = {$urandom, $urandom}; desc_dst_i = {$urandom, $urandom}; desc_len_i = 64'd0;

    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      reg_rsp_ready = 1'b0;
      reg_rsp_error = 1'($urandom_range(0, 1));
      reg_rsp_rdata = {$urandom, $urandom};
      done_ready_i  = 1'b0;
      if (abort_idx >= 0 && idx == abort_idx) begin
        check({tag, " pre-reset req_valid"}, {63'd0, reg_req_valid}, 64'd1);
        reg_rsp_error = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check({tag, " in-reset desc_ready"}, {63'd0, desc_ready_o}, 64'd0);
        check({tag, " post-reset req_valid"}, {63'd0, reg_req_valid}, 64'd0);
        check({tag, " post-reset done_valid"}, {63'd0, done_valid_o}, 64'd0);
        rst_i = 1'b0;
        #1;
        check({tag, " post-reset desc_ready"}, {63'd0, desc_ready_o}, 64'd1);
        return;
      end
      if (idx < exp_q.size()) begin
        t = exp_q[idx];
        check($sformatf("%s req_valid t%0d", tag, idx), {63'd0, reg_req_valid}, 64'd1);
        check($sformatf("%s req_write t%0d", tag, idx), {63'd0, reg_req_write}, {63'd0, t.wr});
        check($sformatf("%s req_addr t%0d", tag, idx), reg_req_addr, t.addr);
        check($sformatf("%s req_wdata t%0d", tag, idx), reg_req_wdata, t.data);
        check($sformatf("%s req_wstrb t%0d", tag, idx), {56'd0, reg_req_wstrb}, t.wr ? 64'hff : 64'h0);
        check($sformatf("%s busy done_valid t%0d", tag, idx), {63'd0, done_valid_o}, 64'd0);
        check($sformatf("%s busy desc_ready t%0d", tag, idx), {63'd0, desc_ready_o}, 64'd0);
        n_valid_cycles++;
        if (idx == sc_stall_idx) begin
          stall_obs++;
          go = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else begin
          go = ($urandom_range(0, 3) != 0);
        end
        if (go) begin
          reg_rsp_ready = 1'b1;
          reg_rsp_error = (idx == sc_err_idx);
          reg_rsp_rdata = slave_rdata(idx);
          if (t.wr) n_wr++; else n_rd++;
          idx++;
        end
      end else begin
        n_valid_cycles += int'(reg_req_valid);
        check({tag, " report req_valid"}, {63'd0, reg_req_valid}, 64'd0);
        check({tag, " report done_valid"}, {63'd0, done_valid_o}, 64'd1);
        check({tag, " report done_error"}, {63'd0, done_error_o}, {63'd0, exp_err});
        check({tag, " report done_id"}, done_id_o, exp_id);
        got_id  = done_id_o;
        got_err = done_error_o;
        if ($urandom_range(0, 2) == 0) begin
          done_ready_i = 1'b1;
          fin = 1'b1;
        end
      end
    end
    check({tag, " completed within budget"}, {63'd0, fin}, 64'd1);
    @(negedge clk_i);
    done_ready_i  = 1'b0;
    reg_rsp_ready = 1'b0;
    reg_rsp_error = 1'b0;
    check({tag, " back to idle"}, {63'd0, done_valid_o}, 64'd0);
  endtask

  task automatic set_sc(input logic [63:0] id, input int match, input int err_idx);
    sc_next_id = id; sc_match = match; sc_err_idx = err_idx;
    sc_stall_idx = -1; sc_stall_cycles = 0;
  endtask

  initial begin
    logic [63:0] len;
    rst_i = 1'b1;
    desc_valid_i = 1'b0; desc_src_i = '0; desc_dst_i = '0; desc_len_i = '0;
    reg_rsp_ready = 1'b0; reg_rsp_error = 1'b0; reg_rsp_rdata = '0; done_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset desc_ready", {63'd0, desc_ready_o}, 64'd0);
    check("reset req_valid", {63'd0, reg_req_valid}, 64'd0);
    check("reset req_write", {63'd0, reg_req_write}, 64'd0);
    check("reset req_addr", reg_req_addr, 64'd0);
    check("reset req_wdata", reg_req_wdata, 64'd0);
    check("reset req_wstrb", {56'd0, reg_req_wstrb}, 64'd0);
    check("reset done_valid", {63'd0, done_valid_o}, 64'd0);
    check("reset done_error", {63'd0, done_error_o}, 64'd0);
    check("reset done_id", done_id_o, 64'd0);
    rst_i = 1'b0;

    // Basic launch: 3 writes, NEXT_ID read, match on third DONE read.
    set_sc(64'd5, 3, -1);
    run_desc("basic", 64'h1000, 64'h2000, 64'h40, -1);
    check("basic writes", 64'(n_wr), 64'd3);
    check("basic reads", 64'(n_rd), 64'd4);
    check("basic id", got_id, 64'd5);
    check("basic err", {63'd0, got_err}, 64'd0);

    // Slave stalls WR_DST for 4 cycles; request must stay put for 5 cycles.
    set_sc(64'h77, 1, -1);
    sc_stall_idx = 1; sc_stall_cycles = 4;
    run_desc("stall", 64'hA000, 64'hB000, 64'h80, -1);
    check("stall cycles on WR_DST", 64'(stall_obs), 64'd5);
    check("stall writes", 64'(n_wr), 64'd3);

    // Error on WR_LEN: no reads at all, error reported with id 0.
    set_sc(64'h99, 1, 2);
    run_desc("err_len", 64'h10, 64'h20, 64'h30, -1);
    check("err_len reads", 64'(n_rd), 64'd0);
    check("err_len id", got_id, 64'd0);
    check("err_len err", {63'd0, got_err}, 64'd1);

    // Zero length: no register traffic.
    set_sc(64'h55, 1, -1);
    run_desc("len0", 64'h10, 64'h20, 64'h0, -1);
    check("len0 valid cycles", 64'(n_valid_cycles), 64'd0);
    check("len0 id", got_id, 64'd0);
    check("len0 err", {63'd0, got_err}, 64'd0);

`ifdef REG_DESC_ISSUER_TIMEOUT_EN
    // DONE never matches: PollLimit reads then timeout error with the launch ID.
    set_sc(64'h1234, 1000, -1);
    run_desc("timeout", 64'h1, 64'h2, 64'h3, -1);
    check("timeout reads", 64'(n_rd), 64'd5);
    check("timeout id", got_id, 64'h1234);
    check("timeout err", {63'd0, got_err}, 64'd1);
`endif

    // Reset while polling with done_ready low, then a clean descriptor afterwards.
    set_sc(64'hCAFE, 1000, -1);
    run_desc("rst_poll", 64'h100, 64'h200, 64'h300, 5);
    set_sc(64'h42, 2, -1);
    run_desc("after_rst", 64'h400, 64'h500, 64'h600, -1);
    check("after_rst id", got_id, 64'h42);

    for (int i = 0; i < 24; i++) begin
      set_sc({$urandom, $urandom}, int'($urandom_range(1, 6)), -1);
      if ($urandom_range(0, 3) == 0) sc_err_idx = int'($urandom_range(0, 7));
      len = ($urandom_range(0, 4) == 0) ? 64'd0 : ({$urandom, $urandom} | 64'd1);
      run_desc($sformatf("rnd%0d", i), {$urandom, $urandom}, {$urandom, $urandom}, len, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
